// File: rtl/wb_stage_pkg.sv
// Shared pipeline types for the writeback stage: result selects, load funct3 codes
// and the WB holding-register state.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'b00,
        ST_FULL      = 2'b01,
        ST_WAIT_LOAD = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bus: instruction handshake, load response, RF write port and hazard/retire status.
interface wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rd;
    logic             in_rd_we;
    logic [1:0]       in_wb_sel;
    logic [XLEN-1:0]  in_alu_result;
    logic [XLEN-1:0]  in_pc_plus4;
    logic [2:0]       in_funct3;
    logic [1:0]       in_addr_lo;
    logic             dmem_rvalid;
    logic [XLEN-1:0]  dmem_rdata;
    logic             rf_wr_en;
    logic [4:0]       rf_wr_addr;
    logic [XLEN-1:0]  rf_wr_data;
    logic             pend_valid;
    logic [4:0]       pend_rd;
    logic             retire;
    logic [CNT_W-1:0] instret;

    modport master (
        output in_valid, in_rd, in_rd_we, in_wb_sel, in_alu_result, in_pc_plus4,
               in_funct3, in_addr_lo, dmem_rvalid, dmem_rdata,
        input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pend_valid, pend_rd,
               retire, instret
    );

    modport slave (
        input  in_valid, in_rd, in_rd_we, in_wb_sel, in_alu_result, in_pc_plus4,
               in_funct3, in_addr_lo, dmem_rvalid, dmem_rdata,
        output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pend_valid, pend_rd,
               retire, instret
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Picks the addressed byte/half/word out of a raw memory word and sign- or zero-extends it.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   result = rdata;
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: holds one retiring instruction, waits for load data,
// drives the register-file write port and counts retired instructions.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input logic       clk,
    input logic       reset_n,
    wb_stage_if.slave bus
);
    wb_state_e        state_q;
    logic [4:0]       rd_q;
    logic             rd_we_q;
    logic [1:0]       wb_sel_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  pc4_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] instret_q;

    logic             retire_w;
    logic             ready_w;
    logic             accept_w;
    logic             wr_en_w;
    logic             pend_w;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  wr_data_w;

    // A held op frees the slot in the same cycle it retires, so accept and retire can overlap.
    assign retire_w = (state_q == ST_FULL) || ((state_q == ST_WAIT_LOAD) && bus.dmem_rvalid);
    assign ready_w  = (state_q != ST_WAIT_LOAD) || bus.dmem_rvalid;
    assign accept_w = bus.in_valid && ready_w;
    assign wr_en_w  = retire_w && rd_we_q && (rd_q != 5'd0);
    assign pend_w   = (state_q == ST_WAIT_LOAD) && rd_we_q && (rd_q != 5'd0);

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (bus.dmem_rdata),
        .result  (load_data)
    );

    always_comb begin
        wr_data_w = '0;
        if (wr_en_w) begin
            if (state_q == ST_WAIT_LOAD)
                wr_data_w = load_data;
            else if (wb_sel_q == WB_PC4)
                wr_data_w = pc4_q;
            else
                wr_data_w = alu_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            wb_sel_q  <= '0;
            alu_q     <= '0;
            pc4_q     <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            instret_q <= '0;
        end else begin
            if (accept_w) begin
                rd_q      <= bus.in_rd;
                rd_we_q   <= bus.in_rd_we;
                wb_sel_q  <= bus.in_wb_sel;
                alu_q     <= bus.in_alu_result;
                pc4_q     <= bus.in_pc_plus4;
                funct3_q  <= bus.in_funct3;
                addr_lo_q <= bus.in_addr_lo;
                state_q   <= (bus.in_wb_sel == WB_LOAD) ? ST_WAIT_LOAD : ST_FULL;
            end else if (retire_w) begin
                state_q <= ST_EMPTY;
            end
            if (retire_w)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = ready_w;
    assign bus.rf_wr_en   = wr_en_w;
    assign bus.rf_wr_addr = rd_q;
    assign bus.rf_wr_data = wr_data_w;
    assign bus.pend_valid = pend_w;
    assign bus.pend_rd    = pend_w ? rd_q : 5'd0;
    assign bus.retire     = retire_w;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/PC+4/load writeback, hazard flag, back-to-back flow and reset.
module tb_wb_stage;
    logic clk;
    logic reset_n;
    int   nVectors;
    int   nMiscompares;

    wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();

    wb_stage #(.XLEN(32), .CNT_W(64)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rd, input logic we,
                                 input logic [1:0] sel, input logic [31:0] alu,
                                 input logic [31:0] pc4, input logic [2:0] f3,
                                 input logic [1:0] addr);
        bus.in_valid      = valid;
        bus.in_rd         = rd;
        bus.in_rd_we      = we;
        bus.in_wb_sel     = sel;
        bus.in_alu_result = alu;
        bus.in_pc_plus4   = pc4;
        bus.in_funct3     = f3;
        bus.in_addr_lo    = addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a load, hold off the response for delay cycles, then check the aligned write.
    task automatic doLoad(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] addr, input logic [31:0] rdata,
                          input int delay, input logic [31:0] exp);
        applyStimulus(1'b1, rd, 1'b1, 2'b01, 32'hDEAD_0001, 32'hDEAD_0002, f3, addr);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            checkOutput({tag, "_pend_valid"}, 64'(bus.pend_valid), 64'd1);
            checkOutput({tag, "_pend_rd"}, 64'(bus.pend_rd), 64'(rd));
            checkOutput({tag, "_ready_low"}, 64'(bus.in_ready), 64'd0);
            checkOutput({tag, "_no_wr"}, 64'(bus.rf_wr_en), 64'd0);
            tick();
        end
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        @(negedge clk);
        checkOutput({tag, "_wr_en"}, 64'(bus.rf_wr_en), 64'd1);
        checkOutput({tag, "_wr_addr"}, 64'(bus.rf_wr_addr), 64'(rd));
        checkOutput({tag, "_wr_data"}, 64'(bus.rf_wr_data), 64'(exp));
        checkOutput({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.dmem_rvalid = 1'b0;
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        reset_n      = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
        applyStimulus(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000, 2'b00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_wr_en", 64'(bus.rf_wr_en), 64'd0);
        checkOutput("rst_wr_data", 64'(bus.rf_wr_data), 64'd0);
        checkOutput("rst_pend", 64'(bus.pend_valid), 64'd0);
        checkOutput("rst_retire", 64'(bus.retire), 64'd0);
        checkOutput("rst_instret", bus.instret, 64'd0);
        tick();
        reset_n = 1'b1;

        applyStimulus(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'b000, 2'b00);
        @(negedge clk);
        checkOutput("alu_accept_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("alu_wr_en", 64'(bus.rf_wr_en), 64'd1);
        checkOutput("alu_wr_addr", 64'(bus.rf_wr_addr), 64'd5);
        checkOutput("alu_wr_data", 64'(bus.rf_wr_data), 64'h1234_5678);
        checkOutput("alu_retire", 64'(bus.retire), 64'd1);
        tick();
        @(negedge clk);
        checkOutput("alu_instret", bus.instret, 64'd1);
        checkOutput("alu_idle_wr", 64'(bus.rf_wr_en), 64'd0);
        tick();

        doLoad("lb", 5'd3, 3'b000, 2'd3, 32'h8012_3456, 4, 32'hFFFF_FF80);
        doLoad("lhu", 5'd7, 3'b101, 2'd2, 32'hBEEF_0000, 1, 32'h0000_BEEF);
        doLoad("lw", 5'd8, 3'b010, 2'd0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
        doLoad("f3_011", 5'd9, 3'b011, 2'd0, 32'hFFFF_FFFF, 1, 32'h0);
        doLoad("lh", 5'd11, 3'b001, 2'd0, 32'h0000_8001, 1, 32'hFFFF_8001);
        doLoad("lbu", 5'd12, 3'b100, 2'd1, 32'h0000_F100, 1, 32'h0000_00F1);
        @(negedge clk);
        checkOutput("load_instret", bus.instret, 64'd7);

        applyStimulus(1'b1, 5'd0, 1'b1, 2'b00, 32'h0000_AAAA, 32'h0, 3'b000, 2'b00);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("x0_wr_en", 64'(bus.rf_wr_en), 64'd0);
        checkOutput("x0_wr_data", 64'(bus.rf_wr_data), 64'd0);
        checkOutput("x0_retire", 64'(bus.retire), 64'd1);
        tick();

        applyStimulus(1'b1, 5'd1, 1'b1, 2'b10, 32'h0000_0111, 32'h0000_1004, 3'b000, 2'b00);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pc4_wr_data", 64'(bus.rf_wr_data), 64'h1004);
        checkOutput("pc4_instret", bus.instret, 64'd8);
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'(10 + i), 1'b1, 2'b00, 32'h100 + 32'(i), 32'h0, 3'b000, 2'b00);
            @(negedge clk);
            checkOutput("b2b_ready", 64'(bus.in_ready), 64'd1);
            if (i > 0) begin
                checkOutput("b2b_wr_en", 64'(bus.rf_wr_en), 64'd1);
                checkOutput("b2b_wr_addr", 64'(bus.rf_wr_addr), 64'(9 + i));
                checkOutput("b2b_wr_data", 64'(bus.rf_wr_data), 64'(32'hFF + 32'(i)));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_last_addr", 64'(bus.rf_wr_addr), 64'd14);
        checkOutput("b2b_last_data", 64'(bus.rf_wr_data), 64'h104);
        tick();
        @(negedge clk);
        checkOutput("b2b_instret", bus.instret, 64'd14);

        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h5555_5555;
        @(negedge clk);
        checkOutput("stray_retire", 64'(bus.retire), 64'd0);
        checkOutput("stray_wr_en", 64'(bus.rf_wr_en), 64'd0);
        tick();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("stray_instret", bus.instret, 64'd14);
        tick();

        applyStimulus(1'b1, 5'd4, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'b00);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstwl_pend", 64'(bus.pend_valid), 64'd1);
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("rstwl_pend_clr", 64'(bus.pend_valid), 64'd0);
        checkOutput("rstwl_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rstwl_instret", bus.instret, 64'd0);
        tick();
        reset_n = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1357_9BDF;
        @(negedge clk);
        checkOutput("rstwl_rv_wr_en", 64'(bus.rf_wr_en), 64'd0);
        checkOutput("rstwl_rv_retire", 64'(bus.retire), 64'd0);
        tick();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("rstwl_final_instret", bus.instret, 64'd0);
        checkOutput("rstwl_final_ready", 64'(bus.in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
